pre_mem_req_queue: RTL
======================

Name: pre_mem_req_queue

Overview:
Parametrised pre-memory stage between EXE and MEM. It holds one instruction, checks alignment and raises AdEL/AdES, and issues a DCache request using the req/addr_ok handshake. It tracks up to MAX_OUT issued-but-unanswered requests (data_ok pending). After a flush it drops responses that belong to squashed requests, so MEM never sees a stale data_ok.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64); wstrb width DATA_W/8
MAX_OUT, 2, max outstanding DCache requests (1..7)
CNT_W, 3, counter width, >= clog2(MAX_OUT+1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (exception/eret commit)
in_valid  in  1  EXE has an instruction
in_allowin  out  1  stage can accept
in_load / in_store  in  1  memory op kind
in_op  in  3  mem_op_t: B,BU,H,HU,W (+LR modes under option)
in_addr  in  ADDR_W  virtual address
in_wdata  in  DATA_W  store data, unaligned (rt)
in_ex  in  1  upstream exception present
out_valid  out  1  to MEM
out_allowin  in  1  MEM can accept
out_ex  out  1  exception (upstream or local)
out_exccode  out  5  AdEL=0x04, AdES=0x05, else 0
out_badvaddr  out  ADDR_W  in_addr on local exception, else 0
out_issued  out  1  instruction sent a DCache request
dc_req  out  1  DCache request valid
dc_wr  out  1  store
dc_size  out  2  0=byte,1=half,2=word
dc_wstrb  out  DATA_W/8  byte enables
dc_addr  out  ADDR_W  request address
dc_wdata  out  DATA_W  lane-shifted store data
dc_addr_ok  in  1  request accepted
dc_data_ok  in  1  response returned (in issue order)
rsp_valid  out  1  data_ok for a live request (to MEM)
outstanding  out  CNT_W  live+dropped pending count

Behaviour:
- Slot FSM: EMPTY -> (in_valid & in_allowin) -> REQ if mem op & no exception & !inhibit, else HOLD. REQ -> HOLD on dc_req&dc_addr_ok. HOLD -> EMPTY if out_allowin & !in_valid, stays full with the new instruction if in_valid. Any state -> EMPTY on flush (flush wins over a same-cycle accept).
- in_allowin = EMPTY | (HOLD & out_allowin). out_valid = (state==HOLD).
- dc_req = (state==REQ) & (outstanding<MAX_OUT) & !flush. Request fields are held stable while REQ is not acknowledged.
- Alignment: H/HU/SH need addr[0]==0; W needs addr[1:0]==0. On violation: load AdEL, store AdES; no request.
- Exception priority: in_ex over local exception. An exception or upstream in_ex sets sticky inhibit; while set, mem ops go straight to HOLD without a request. Inhibit clears only on flush or reset.
- wstrb: byte 1<<addr[1:0]; half 3<<addr[1:0]; word all ones; loads 0. wdata is replicated across byte/half lanes.
- outstanding: +1 on accepted request, -1 on data_ok, both in the same cycle = no change. Never exceeds MAX_OUT.
- drop counter: on flush, drop <= outstanding (net of the same-cycle data_ok). While drop>0, each data_ok decrements drop and rsp_valid=0. Otherwise rsp_valid=dc_data_ok.
- Reset (async): state EMPTY, counters 0, inhibit 0. All outputs 0 except in_allowin=1.
- dc_data_ok while outstanding==0 is illegal; an assertion fires.

Optional Feature:
Macro PMS_UNALIGNED_LR_EN. When defined, in_op adds LWL/LWR/SWL/SWR. These raise no alignment exception. SWL wstrb = (1<<(addr[1:0]+1))-1 with data shifted right by (3-addr[1:0])*8. SWR wstrb = ~((1<<addr[1:0])-1) with data shifted left by addr[1:0]*8. LWL/LWR request a word at addr&~3. When not defined, these encodings are treated as W with a normal alignment check.

Decomposition:
- cpu package: mem_op_t enum, exccode constants EXC_ADEL/EXC_ADES, pms_state_t.
- One sub-module, pms_req_gen: combinational alignment check, size, wstrb and wdata shift (holds all PMS_UNALIGNED_LR_EN logic).
- The counters and FSM live in the top module.

Test Plan:
- SW addr 0x1000, data 0xDEADBEEF, addr_ok after 2 cycles -> dc_req held 3 cycles, wstrb 0xF, outstanding 0->1, out_valid after ack.
- LH addr 0x1001 -> no dc_req, out_ex=1, exccode 0x04, badvaddr 0x1001; following LW is inhibited until flush.
- SB addr 0x2003, data 0x000000AB -> wstrb 0x8, wdata 0xABABABAB, size 0.
- MAX_OUT=2: three back-to-back LW with data_ok withheld -> third dc_req waits at outstanding==2 and issues the cycle after the first data_ok.
- Two requests outstanding, then flush -> next two data_ok give rsp_valid=0; a third request after flush gets rsp_valid=1.
- resetn pulled low mid-REQ -> next edge: dc_req=0, outstanding=0, in_allowin=1.

Source files
------------

// File: rtl/pre_mem_req_queue_pkg.sv
// Shared types for the pre-memory request stage: memory op encoding, exception codes, slot states.
// Latency: n/a (types and constants only).
// Backpressure: n/a. PMS_UNALIGNED_LR_EN gives OP_WL/OP_WR their LWL/SWL and LWR/SWR meaning.
package pre_mem_req_queue_pkg;

    // Load/store kind comes from in_load/in_store, so OP_WL covers LWL and SWL, OP_WR covers LWR and SWR.
    typedef enum logic [2:0] {
        OP_B   = 3'd0,
        OP_BU  = 3'd1,
        OP_H   = 3'd2,
        OP_HU  = 3'd3,
        OP_W   = 3'd4,
        OP_WL  = 3'd5,
        OP_WR  = 3'd6,
        OP_RSV = 3'd7
    } mem_op_t;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } pms_state_t;

    // Address-error code depends only on the direction of the access.
    function automatic logic [4:0] adr_exccode(input logic is_store);
        return is_store ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/pms_req_gen.sv
// Builds DCache request fields from an op/address/data triple: alignment check, size, byte enables, lane data.
// Latency: purely combinational.
// Backpressure: none; PMS_UNALIGNED_LR_EN enables LWL/LWR/SWL/SWR handling, otherwise those codes act as W.
module pms_req_gen
    import pre_mem_req_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [2:0]          op,
    input  logic                store,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                misaligned,
    output logic [1:0]          size,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_wdata
);

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);

    logic [LW-1:0]     lane;
    logic [LW-1:0]     wlane;
    logic [1:0]        boff;
    logic [NB-1:0]     strb_all;
    logic [DATA_W-1:0] rep;

    assign lane  = addr[LW-1:0];
    assign wlane = lane & ~LW'(3);
    assign boff  = addr[1:0];

`ifdef PMS_UNALIGNED_LR_EN
    logic [3:0]  lr_strb;
    logic [31:0] lr_data;

    // Partial-word store lanes: SWL fills the low bytes up to addr, SWR fills from addr upward.
    always_comb begin
        lr_strb = 4'((5'd1 << ({1'b0, boff} + 3'd1)) - 5'd1);
        lr_data = wdata[31:0] >> {2'd3 - boff, 3'b000};
        if (mem_op_t'(op) == OP_WR) begin
            lr_strb = ~((4'd1 << boff) - 4'd1);
            lr_data = wdata[31:0] << {boff, 3'b000};
        end
    end
`endif

    // Decode op into size/alignment/lanes; loads carry no byte enables and no data.
    always_comb begin
        misaligned = 1'b0;
        size       = SZ_WORD;
        strb_all   = NB'(4'hF) << wlane;
        rep        = {(NB/4){wdata[31:0]}};
        req_addr   = addr;
        case (mem_op_t'(op))
            OP_B, OP_BU: begin
                size     = SZ_BYTE;
                strb_all = NB'(1) << lane;
                rep      = {NB{wdata[7:0]}};
            end
            OP_H, OP_HU: begin
                misaligned = addr[0];
                size       = SZ_HALF;
                strb_all   = NB'(3) << lane;
                rep        = {(NB/2){wdata[15:0]}};
            end
`ifdef PMS_UNALIGNED_LR_EN
            OP_WL, OP_WR: begin
                req_addr = addr & ~ADDR_W'(3);
                strb_all = NB'(lr_strb) << wlane;
                rep      = {(NB/4){lr_data}};
            end
`endif
            default: begin
                misaligned = |boff;
            end
        endcase
        wstrb     = store ? strb_all : '0;
        req_wdata = store ? rep : '0;
    end

endmodule

// File: rtl/pre_mem_req_queue.sv
// One-entry EXE->MEM stage: checks alignment, issues a DCache request, tracks outstanding and squashed responses.
// Latency: one cycle to REQ after accept, then until dc_addr_ok (and outstanding < MAX_OUT); HOLD until MEM takes it.
// Backpressure: in_allowin only when empty or MEM accepts; dc_req stalls at MAX_OUT. PMS_UNALIGNED_LR_EN in pms_req_gen.
module pre_mem_req_queue
    import pre_mem_req_queue_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_allowin,
    input  logic                in_load,
    input  logic                in_store,
    input  logic [2:0]          in_op,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                in_ex,
    output logic                out_valid,
    input  logic                out_allowin,
    output logic                out_ex,
    output logic [4:0]          out_exccode,
    output logic [ADDR_W-1:0]   out_badvaddr,
    output logic                out_issued,
    output logic                dc_req,
    output logic                dc_wr,
    output logic [1:0]          dc_size,
    output logic [DATA_W/8-1:0] dc_wstrb,
    output logic [ADDR_W-1:0]   dc_addr,
    output logic [DATA_W-1:0]   dc_wdata,
    input  logic                dc_addr_ok,
    input  logic                dc_data_ok,
    output logic                rsp_valid,
    output logic [CNT_W-1:0]    outstanding
);

    localparam int NB = DATA_W / 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    pms_state_t        state;
    pms_state_t        state_nxt;
    logic              inhibit;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              g_mis;
    logic [1:0]        g_size;
    logic [NB-1:0]     g_wstrb;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    logic is_mem;
    logic local_ex;
    logic new_ex;
    logic go_req;
    logic accept;
    logic ack;

    // Request fields are computed on the incoming instruction and captured at accept,
    // so they stay stable while REQ waits for dc_addr_ok.
    pms_req_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_gen (
        .op         (in_op),
        .store      (in_store),
        .addr       (in_addr),
        .wdata      (in_wdata),
        .misaligned (g_mis),
        .size       (g_size),
        .wstrb      (g_wstrb),
        .req_addr   (g_addr),
        .req_wdata  (g_wdata)
    );

    assign is_mem   = in_load | in_store;
    assign local_ex = is_mem & g_mis;
    assign new_ex   = in_ex | local_ex;
    assign go_req   = is_mem & ~new_ex & ~inhibit;

    assign in_allowin = (state == ST_EMPTY) | ((state == ST_HOLD) & out_allowin);
    assign out_valid  = (state == ST_HOLD);
    assign accept     = in_valid & in_allowin & ~flush;
    assign dc_req     = (state == ST_REQ) & (outstanding < MAX_CNT) & ~flush;
    assign ack        = dc_req & dc_addr_ok;

    assign cnt_nxt   = outstanding + CNT_W'(ack) - CNT_W'(dc_data_ok);
    assign rsp_valid = dc_data_ok & (drop == '0);

    // Slot state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next slot state; flush overrides everything, including a same-cycle accept.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (accept) state_nxt = go_req ? ST_REQ : ST_HOLD;
            end
            ST_REQ: begin
                if (ack) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept)           state_nxt = go_req ? ST_REQ : ST_HOLD;
                else if (out_allowin) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // Capture the instruction and its request/exception fields on accept; mark issue on ack.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dc_wr        <= 1'b0;
            dc_size      <= '0;
            dc_wstrb     <= '0;
            dc_addr      <= '0;
            dc_wdata     <= '0;
            out_ex       <= 1'b0;
            out_exccode  <= EXC_NONE;
            out_badvaddr <= '0;
            out_issued   <= 1'b0;
        end else if (accept) begin
            dc_wr        <= in_store;
            dc_size      <= g_size;
            dc_wstrb     <= g_wstrb;
            dc_addr      <= g_addr;
            dc_wdata     <= g_wdata;
            out_ex       <= new_ex;
            out_exccode  <= (!in_ex && local_ex) ? adr_exccode(in_store) : EXC_NONE;
            out_badvaddr <= (!in_ex && local_ex) ? in_addr : '0;
            out_issued   <= 1'b0;
        end else if (ack) begin
            out_issued   <= 1'b1;
        end
    end

    // Once an exception enters the stage, later memory ops must not touch the cache until flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inhibit <= 1'b0;
        end else if (flush) begin
            inhibit <= 1'b0;
        end else if (accept && new_ex) begin
            inhibit <= 1'b1;
        end
    end

    // Outstanding requests, and how many of them belong to squashed instructions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= cnt_nxt;
            if (flush) begin
                drop <= cnt_nxt;
            end else if (dc_data_ok && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
        end
    end

    data_ok_without_request: assert property (
        @(posedge clk) disable iff (!resetn) !(dc_data_ok && (outstanding == '0))
    );

    outstanding_bounded: assert property (
        @(posedge clk) disable iff (!resetn) (outstanding <= MAX_CNT)
    );

endmodule
